// File: rtl/gearbox_adapter_if.sv
// gearbox_adapter_if: stream bundle for the width-converting gearbox.
// in_*: IW-bit producer side; out_*: OW-bit consumer side with nbits.
interface gearbox_adapter_if #(
    parameter int IW = 56,
    parameter int OW = 64
);
    localparam int NW = $clog2(OW + 1);

    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic [NW-1:0] out_nbits;
    logic          out_ready;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  out_data, out_valid, out_last, out_nbits,
        output out_ready
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output out_data, out_valid, out_last, out_nbits,
        input  out_ready
    );
endinterface

// File: rtl/gearbox_adapter.sv
// gearbox_adapter: packs IW-bit words LSB-first into OW-bit words.
// Ports: clk, rst (sync, active-low), bus (slave view: in_*, out_*).
module gearbox_adapter #(
    parameter int IW = 56,
    parameter int OW = 64
) (
    input  logic              clk,
    input  logic              rst,
    gearbox_adapter_if.slave  bus
);
    localparam int BW = IW + OW;
    localparam int CW = $clog2(BW + 1);
    localparam int NW = $clog2(OW + 1);

    localparam logic [CW-1:0] IW_C   = CW'(IW);
    localparam logic [CW-1:0] OW_C   = CW'(OW);
    localparam logic [CW-1:0] BW_C   = CW'(BW);
    localparam logic [CW-1:0] ROOM_C = CW'(BW - IW);

    logic [BW-1:0] bits_q;
    logic [BW-1:0] bits_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flush_q;
    logic          flush_d;

    logic          full;
    logic          i_ready;
    logic          o_valid;
    logic          o_last;
    logic [NW-1:0] nbits;
    logic [OW-1:0] o_data;
    logic          in_fire;
    logic          out_fire;
    logic [CW-1:0] used;
    logic [CW-1:0] base;

    // Output view and readiness come only from registers; rst gates
    // them so nothing looks valid while reset is held.
    always_comb begin
        full    = cnt_q >= OW_C;
        i_ready = rst & (cnt_q <= ROOM_C) & ~flush_q;
        o_valid = rst & (full | (flush_q & (cnt_q != '0)));
        o_last  = o_valid & flush_q & (cnt_q <= OW_C);
        nbits   = '0;
        if (o_valid) begin
            nbits = full ? NW'(OW) : NW'(cnt_q);
        end
        o_data = '0;
        for (int i = 0; i < OW; i++) begin
            o_data[i] = rst & bits_q[i] & (CW'(i) < cnt_q);
        end
    end

    assign bus.in_ready  = i_ready;
    assign bus.out_valid = o_valid;
    assign bus.out_last  = o_last;
    assign bus.out_nbits = nbits;
    assign bus.out_data  = o_data;

    assign in_fire  = bus.in_valid & i_ready;
    assign out_fire = o_valid & bus.out_ready;

    // Drain and fill in the same cycle: the new word lands just above
    // whatever survives the right shift.
    always_comb begin
        used   = out_fire ? CW'(nbits) : '0;
        base   = cnt_q - used;
        bits_d = bits_q >> used;
        if (in_fire) begin
            bits_d = bits_d | (BW'(bus.in_data) << base);
        end
        cnt_d   = base + (in_fire ? IW_C : '0);
        flush_d = flush_q;
        if (out_fire & o_last) begin
            flush_d = 1'b0;
        end
        if (in_fire & bus.in_last) begin
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bits_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    // A frame close can only fire with in_ready low, so it never
    // coincides with accepting a new last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (cnt_q <= BW_C);
            assert (!(in_fire && bus.in_last && out_fire && o_last));
        end
    end
endmodule
